// File: rtl/chunked_adder_if.sv
// Operand/result bundle for chunked_adder. With CHUNKED_ADDER_OVF_EN defined the
// bundle also carries the signed-overflow flag ovf.
interface chunked_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef CHUNKED_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
`else
    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout
    );
`endif
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock with a registered ripple carry.
// Optional signed-overflow output enabled by CHUNKED_ADDER_OVF_EN.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic           clk,
    input logic           rst_n,
    chunked_adder_if.slave bus
);

    localparam int unsigned NCH  = WIDTH / CHUNK;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  s_q;
    logic              busy_q;
    logic              done_q;
    logic              cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    logic              ovf_q;
`endif

    logic [31:0]       lsb;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    chunk_sum;
    logic              last_chunk;
    logic              msb_carry_in;

    always_comb begin
        lsb          = 32'(idx_q) * CHUNK;
        a_chunk      = a_q[lsb +: CHUNK];
        b_chunk      = b_q[lsb +: CHUNK];
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk   = (idx_q == IDXW'(NCH - 1));
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1, so fold sub into b and the carry-in.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s_q[lsb +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry_q           <= chunk_sum[CHUNK];
                    idx_q             <= idx_q + IDXW'(1);
                    if (last_chunk) begin
                        cout_q  <= chunk_sum[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
                        ovf_q   <= msb_carry_in ^ chunk_sum[CHUNK];
`endif
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef CHUNKED_ADDER_OVF_EN
    logic unused_msb_carry_in;
    assign unused_msb_carry_in = msb_carry_in;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder at WIDTH=16, CHUNK=4.
// Covers CHUNKED_ADDER_OVF_EN when that macro is defined.
module tb_chunked_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;
    int   busy_cyc;
    int   dones;
    int   done_at;

    chunked_adder_if #(.WIDTH(16)) bus ();

    chunked_adder #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents operands and pulses start so it is sampled on exactly one rising edge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                            input logic tsub);
        @(negedge clk);
        bus.a     = ta;
        bus.b     = tb;
        bus.cin   = tcin;
        bus.sub   = tsub;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Negedge samples after the start edge until done; bounded at 50 cycles.
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        while (l < 50) begin
            @(negedge clk);
            l++;
            if (bus.busy) bc++;
            if (bus.done) break;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub, input logic [15:0] exp_s,
                                 input logic exp_c);
        start_op(ta, tb, tcin, tsub);
        wait_done(lat, busy_cyc);
        check({tag, "_lat"}, lat, 32'd6);
        check({tag, "_s"}, {16'h0, bus.s}, {16'h0, exp_s});
        check({tag, "_cout"}, {31'h0, bus.cout}, {31'h0, exp_c});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_s", {16'h0, bus.s}, 32'h0);
        check("rst_cout", {31'h0, bus.cout}, 32'h0);
        rst_n = 1'b1;

        // Basic add with latency, busy length and single-cycle done
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(lat, busy_cyc);
        check("add0_lat", lat, 32'd6);
        check("add0_busy_cycles", busy_cyc, 32'd4);
        check("add0_s", {16'h0, bus.s}, 32'h5555);
        check("add0_cout", {31'h0, bus.cout}, 32'h0);
        check("add0_busy_at_done", {31'h0, bus.busy}, 32'h0);
        @(negedge clk);
        check("add0_done_pulse", {31'h0, bus.done}, 32'h0);
        check("add0_s_hold", {16'h0, bus.s}, 32'h5555);

        // Carry-out wrap, with and without carry-in
        run_and_check("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_and_check("wrap_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1);

        // Subtract; cin must be ignored when sub=1
        run_and_check("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_and_check("sub_ok", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);

        // Start in RUN and in DONE ignored; operand change after start ignored
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.a   = 16'hFFFF;
        bus.b   = 16'hFFFF;
        bus.cin = 1'b1;
        bus.sub = 1'b1;
        dones   = 0;
        done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
            if (i == 2 || i == 5) bus.start = 1'b1;
            if (i == 3 || i == 6) bus.start = 1'b0;
        end
        check("ign_done_count", dones, 32'd1);
        check("ign_done_at", done_at, 32'd6);
        check("ign_s", {16'h0, bus.s}, 32'h3333);
        check("ign_cout", {31'h0, bus.cout}, 32'h0);
        check("ign_busy_idle", {31'h0, bus.busy}, 32'h0);

        // Leave cout=1 behind, then abort an operation in its second RUN cycle
        run_and_check("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        start_op(16'h0007, 16'h0008, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'h0, bus.busy}, 32'h1);
        check("mid_s_chunk0", {16'h0, bus.s}, 32'h000F);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        check("abort_s", {16'h0, bus.s}, 32'h0);
        check("abort_cout", {31'h0, bus.cout}, 32'h0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        rst_n = 1'b1;
        run_and_check("post_rst", 16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 16'hB4B5, 1'b0);

`ifdef CHUNKED_ADDER_OVF_EN
        run_and_check("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        check("ovf_add_ovf", {31'h0, bus.ovf}, 32'h1);
        run_and_check("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        check("ovf_sub_ovf", {31'h0, bus.ovf}, 32'h1);
        run_and_check("ovf_none", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
        check("ovf_none_ovf", {31'h0, bus.ovf}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
